// File: rtl/sw_bounce_gen.sv
// sw_bounce_gen: mechanical switch emulator with LFSR-driven contact bounce.
// Turns a clean level request into a reproducible bounce burst, then settles.
module sw_bounce_gen #(
  parameter int          BOUNCE_CYC = 64,
  parameter int          SETTLE_CYC = 32,
  parameter int          SEG_W      = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_1,
  input  logic       cmd_i,
  output logic       sw_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] edge_cnt_o
);

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int SET_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int WIN_W = $clog2(BOUNCE_CYC + 2);
  localparam int SET_W = $clog2(SET_EFF + 2);
  localparam int SEG_CW = SEG_W + 1;
  localparam logic [WIN_W-1:0] WIN_LD = WIN_W'(BOUNCE_CYC);
  localparam logic [SET_W-1:0] SET_LD = SET_W'(SET_EFF);
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  state_t              state;
  logic                level;
  logic                target;
  logic [15:0]         lfsr;
  logic [WIN_W-1:0]    win;
  logic [SEG_CW-1:0]   seg;
  logic [SET_W-1:0]    set_cnt;

  logic [15:0]         lfsr_adv;
  logic [SEG_CW-1:0]   seg_ld;
  logic                sw_nxt;
  logic                win_end;
  logic                seg_end;
  logic                req;

  assign lfsr_adv = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? TAPS : 16'h0000);
  assign seg_ld  = {1'b0, lfsr[SEG_W-1:0]} + SEG_CW'(1);
  assign win_end = (win == WIN_W'(1));
  assign seg_end = (seg == SEG_CW'(1));
  assign req     = (cmd_i != level);

  // Window end forces the target level and overrides a segment toggle.
  always_comb begin
    sw_nxt = sw_o;
    unique case (state)
      IDLE: begin
        if (req) begin
          sw_nxt = (BOUNCE_CYC > 0) ? ~sw_o : cmd_i;
        end
      end
      BOUNCE: begin
        if (win_end) begin
          sw_nxt = target;
        end else if (seg_end) begin
          sw_nxt = ~sw_o;
        end
      end
      SETTLE: sw_nxt = target;
      default: sw_nxt = sw_o;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_1) begin
      state      <= IDLE;
      level      <= 1'b0;
      target     <= 1'b0;
      lfsr       <= SEED_EFF;
      win        <= '0;
      seg        <= '0;
      set_cnt    <= '0;
      sw_o       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      edge_cnt_o <= 8'd0;
    end else begin
      sw_o   <= sw_nxt;
      done_o <= 1'b0;
      if (state == BOUNCE) begin
        lfsr <= lfsr_adv;
      end
      if ((sw_nxt != sw_o) && (edge_cnt_o != 8'hFF)) begin
        edge_cnt_o <= edge_cnt_o + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            target     <= cmd_i;
            busy_o     <= 1'b1;
            edge_cnt_o <= 8'd1;
            if (BOUNCE_CYC > 0) begin
              state <= BOUNCE;
              win   <= WIN_LD;
              seg   <= seg_ld;
            end else begin
              state   <= SETTLE;
              set_cnt <= SET_LD;
            end
          end
        end
        BOUNCE: begin
          win <= win - WIN_W'(1);
          if (win_end) begin
            state   <= SETTLE;
            set_cnt <= SET_LD;
          end else if (seg_end) begin
            seg <= seg_ld;
          end else begin
            seg <= seg - SEG_CW'(1);
          end
        end
        SETTLE: begin
          if (set_cnt == SET_W'(1)) begin
            state  <= IDLE;
            level  <= target;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            set_cnt <= set_cnt - SET_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_bounce_gen.sv
// tb_sw_bounce_gen: random transitions checked against an event-list
// bounce model, plus no-bounce, reset-abort and debounce loopback cases.
module tb_sw_bounce_gen;

  localparam int B  = 64;
  localparam int S  = 32;
  localparam int S0 = 4;
  localparam int DB = 12;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_a = 1'b0;
  logic       cmd_b = 1'b0;
  logic       sw_a, busy_a, done_a;
  logic       sw_z, busy_z, done_z;
  logic       sw_b, busy_b, done_b;
  logic [7:0] cnt_a, cnt_z, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  logic        m_level;
  int          m_cnt;

  always #5 clk = ~clk;

  sw_bounce_gen dut (
    .clk_i(clk), .rst_1(rst), .cmd_i(cmd_a),
    .sw_o(sw_a), .busy_o(busy_a), .done_o(done_a),
    .edge_cnt_o(cnt_a)
  );

  sw_bounce_gen #(.SEED(16'h0000)) dut_z (
    .clk_i(clk), .rst_1(rst), .cmd_i(cmd_a),
    .sw_o(sw_z), .busy_o(busy_z), .done_o(done_z),
    .edge_cnt_o(cnt_z)
  );

  sw_bounce_gen #(.BOUNCE_CYC(0), .SETTLE_CYC(S0)) dut0 (
    .clk_i(clk), .rst_1(rst), .cmd_i(cmd_b),
    .sw_o(sw_b), .busy_o(busy_b), .done_o(done_b),
    .edge_cnt_o(cnt_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] x);
    adv = {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_sw", int'(sw_a), int'(m_level));
      chk("idle_busy", int'(busy_a), 0);
      chk("idle_done", int'(done_a), 0);
      chk("idle_cnt", int'(cnt_a), m_cnt);
      chk("idle_sw_z", int'(sw_z), int'(m_level));
    end
  endtask

  task automatic xfer0(input logic tgt);
    cmd_b = tgt;
    @(posedge clk);
    for (int c = 1; c <= S0 + 1; c++) begin
      @(negedge clk);
      chk("nb_sw", int'(sw_b), int'(tgt));
      chk("nb_busy", int'(busy_b), int'(c <= S0));
      chk("nb_done", int'(done_b), int'(c == S0 + 1));
      chk("nb_cnt", int'(cnt_b), 1);
    end
  endtask

  task automatic xfer(input logic tgt, input bit wiggle,
                      input int rst_at);
    logic [15:0] a [0:B];
    bit          tog [0:B];
    logic        exp_sw [1:B+S+1];
    logic [15:0] sel;
    logic        prev, osw, db_st, db_last;
    int          e, ecnt, ocnt, db_run, db_flips;
    a[0] = m_lfsr;
    for (int k = 1; k <= B; k++) a[k] = adv(a[k-1]);
    for (int k = 0; k <= B; k++) tog[k] = 1'b0;
    // Toggle events: edge 0 is first contact; each next one is a
    // segment later, length drawn from the LFSR value at that edge.
    e = 0;
    while (e < B) begin
      tog[e] = 1'b1;
      sel = (e == 0) ? a[0] : a[e-1];
      e = e + 1 + int'(sel[2:0]);
    end
    prev = m_level;
    for (int c = 1; c <= B + S + 1; c++) begin
      if (c <= B) begin
        prev = prev ^ tog[c-1];
        exp_sw[c] = prev;
      end else begin
        exp_sw[c] = tgt;
      end
    end
    cmd_a = tgt;
    @(posedge clk);
    ecnt = 0; ocnt = 0; prev = m_level; osw = m_level;
    db_st = m_level; db_last = m_level; db_run = DB; db_flips = 0;
    for (int c = 1; c <= B + S + 1; c++) begin
      @(negedge clk);
      if (exp_sw[c] != prev) begin
        ecnt = (ecnt < 255) ? ecnt + 1 : 255;
        prev = exp_sw[c];
      end
      if (sw_a != osw) ocnt++;
      osw = sw_a;
      chk("sw", int'(sw_a), int'(exp_sw[c]));
      chk("busy", int'(busy_a), int'(c <= B + S));
      chk("done", int'(done_a), int'(c == B + S + 1));
      chk("cnt", int'(cnt_a), ecnt);
      chk("sw_z", int'(sw_z), int'(exp_sw[c]));
      chk("done_z", int'(done_z), int'(c == B + S + 1));
      chk("cnt_z", int'(cnt_z), ecnt);
      db_run = (sw_a == db_last) ? db_run + 1 : 1;
      db_last = sw_a;
      if (db_run >= DB && sw_a != db_st) begin
        db_st = sw_a;
        db_flips++;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmd_a = 1'b0;
        chk("rst_sw", int'(sw_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_sw_z", int'(sw_z), 0);
        m_lfsr = SEED; m_level = 1'b0; m_cnt = 0;
        return;
      end
      if (c == B + S + 1) cmd_a = tgt;
      else if (wiggle) cmd_a = 1'($urandom_range(0, 1));
    end
    chk("cnt_odd", int'(cnt_a[0]), 1);
    chk("obs_edges", int'(cnt_a), ocnt);
    chk("db_flips", db_flips, 1);
    chk("db_state", int'(db_st), int'(tgt));
    m_lfsr = a[B];
    m_level = tgt;
    m_cnt = ecnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    m_lfsr = SEED; m_level = 1'b0; m_cnt = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0_sw", int'(sw_a), 0);
    chk("rst0_busy", int'(busy_a), 0);
    chk("rst0_done", int'(done_a), 0);
    chk("rst0_cnt", int'(cnt_a), 0);
    chk("rst0_sw_b", int'(sw_b), 0);
    rst = 1'b0;
    idle_a(200);

    xfer0(1'b1);
    repeat (3) @(negedge clk);
    xfer0(1'b0);
    repeat (3) @(negedge clk);
    chk("nb_idle_busy", int'(busy_b), 0);

    xfer(1'b1, 1'b0, 0);
    idle_a(5);
    for (int i = 0; i < 6; i++) begin
      xfer(~m_level, 1'b1, 0);
      idle_a($urandom_range(1, 6));
    end
    if (m_level) begin
      xfer(1'b0, 1'b1, 0);
      idle_a(3);
    end

    xfer(1'b1, 1'b0, 20);
    idle_a(4);
    xfer(1'b1, 1'b0, 0);
    idle_a(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
